// File: rtl/fp_compare_pipe.sv
// Pipelined single-precision compare/min/max (FEQ/FLT/FLE/FMIN/FMAX) with RISC-V NaN rules.
// Result is evaluated from order-preserving unsigned keys, then carried through PIPELINE stages.
module fp_compare_pipe #(
   parameter int PIPELINE = 2,
   parameter int TAG_W    = 5
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_nv,
   output logic [TAG_W-1:0] out_tag
);
   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
   localparam logic [2:0]  OP_FLE = 3'b000, OP_FLT = 3'b001, OP_FEQ = 3'b010,
                           OP_FMIN = 3'b100, OP_FMAX = 3'b101;

   logic        a_nan, b_nan, a_snan, b_snan, any_nan, any_snan, both_zero;
   logic [31:0] key_a, key_b;
   logic        key_lt, key_eq, cmp_lt, cmp_eq;
   logic [31:0] eval_result;
   logic        eval_nv;

   always_comb begin
      a_nan     = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
      b_nan     = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'd0);
      a_snan    = a_nan && !in_a[22];
      b_snan    = b_nan && !in_b[22];
      any_nan   = a_nan || b_nan;
      any_snan  = a_snan || b_snan;
      both_zero = (in_a[30:0] == 31'd0) && (in_b[30:0] == 31'd0);
      // Negative values invert fully so larger magnitude sorts lower; positives just flip the sign bit.
      key_a     = in_a[31] ? ~in_a : (in_a ^ 32'h8000_0000);
      key_b     = in_b[31] ? ~in_b : (in_b ^ 32'h8000_0000);
      key_lt    = key_a < key_b;
      key_eq    = key_a == key_b;
      // Compares treat -0 == +0; min/max keep the key order where -0 < +0.
      cmp_eq    = key_eq || both_zero;
      cmp_lt    = key_lt && !both_zero;

      eval_result = 32'd0;
      eval_nv     = 1'b0;
      case (in_op)
         OP_FLE: begin
            eval_result = {31'd0, !any_nan && (cmp_lt || cmp_eq)};
            eval_nv     = any_nan;
         end
         OP_FLT: begin
            eval_result = {31'd0, !any_nan && cmp_lt};
            eval_nv     = any_nan;
         end
         OP_FEQ: begin
            eval_result = {31'd0, !any_nan && cmp_eq};
            eval_nv     = any_snan;
         end
         OP_FMIN, OP_FMAX: begin
            eval_nv = any_snan;
            if (a_nan && b_nan)
               eval_result = CANON_NAN;
            else if (a_nan)
               eval_result = in_b;
            else if (b_nan)
               eval_result = in_a;
            else if (in_op == OP_FMIN)
               eval_result = (key_lt || key_eq) ? in_a : in_b;
            else
               eval_result = key_lt ? in_b : in_a;
         end
         default: begin
            eval_result = 32'd0;
            eval_nv     = 1'b0;
         end
      endcase
   end

   logic             valid_q  [PIPELINE];
   logic             valid_d  [PIPELINE];
   logic [31:0]      result_q [PIPELINE];
   logic [31:0]      result_d [PIPELINE];
   logic             nv_q     [PIPELINE];
   logic             nv_d     [PIPELINE];
   logic [TAG_W-1:0] tag_q    [PIPELINE];
   logic [TAG_W-1:0] tag_d    [PIPELINE];
   logic             advance;

   assign out_valid  = valid_q[PIPELINE-1];
   assign out_result = result_q[PIPELINE-1];
   assign out_nv     = nv_q[PIPELINE-1];
   assign out_tag    = tag_q[PIPELINE-1];
   assign advance    = !out_valid || out_ready;
   assign in_ready   = advance;

   // The last stage only loads on a valid op so out_* hold their value across bubbles.
   always_comb begin
      for (int i = 0; i < PIPELINE; i++) begin
         valid_d[i]  = valid_q[i];
         result_d[i] = result_q[i];
         nv_d[i]     = nv_q[i];
         tag_d[i]    = tag_q[i];
      end
      if (advance) begin
         valid_d[0] = in_valid;
         if (in_valid || (PIPELINE > 1)) begin
            result_d[0] = eval_result;
            nv_d[0]     = eval_nv;
            tag_d[0]    = in_tag;
         end
         for (int i = 1; i < PIPELINE; i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1] || (i < PIPELINE - 1)) begin
               result_d[i] = result_q[i-1];
               nv_d[i]     = nv_q[i-1];
               tag_d[i]    = tag_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < PIPELINE; i++) begin
            valid_q[i]  <= 1'b0;
            result_q[i] <= 32'd0;
            nv_q[i]     <= 1'b0;
            tag_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < PIPELINE; i++) begin
            valid_q[i]  <= valid_d[i];
            result_q[i] <= result_d[i];
            nv_q[i]     <= nv_d[i];
            tag_q[i]    <= tag_d[i];
         end
      end
   end
endmodule
